ring_inject_ctrl: RTL

RING_INJECT_CTRL -- requirements
Module: ring_inject_ctrl

---
 rtl/ring_pkg.sv | 37 +++
 rtl/ring_inj_fifo.sv | 54 +++++
 rtl/ring_inject_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ring_pkg.sv
// Shared definitions for the ring injection controller: packet field layout,
// direction and traffic-pattern encodings, FSM states and routing helpers.
package ring_pkg;

  localparam int VALID_BIT = 48;
  localparam int TS_LSB    = 32;
  localparam int TS_W      = 16;
  localparam int SRC_LSB   = 16;
  localparam int SRC_W     = 16;
  localparam int DST_LSB   = 0;
  localparam int DST_W     = 16;

  localparam logic DIR_EAST = 1'b0;
  localparam logic DIR_WEST = 1'b1;

  localparam int PAT_BIT_COMPLEMENT = 0;
  localparam int PAT_EAST_NEIGHBOUR = 1;

  typedef enum logic [1:0] {
    ST_GEN,
    ST_DRAIN,
    ST_DONE
  } inj_state_e;

  function automatic int calc_dst(input int num_nodes, input int src, input int pattern);
    if (pattern == PAT_EAST_NEIGHBOUR) return (src + 1) % num_nodes;
    return (~src) & (num_nodes - 1);
  endfunction

  // Shortest way round the ring; an exact half-ring tie goes east.
  function automatic logic calc_dir(input int num_nodes, input int src, input int dst);
    int hops_east;
    hops_east = (dst - src + num_nodes) % num_nodes;
    return (hops_east <= num_nodes / 2) ? DIR_EAST : DIR_WEST;
  endfunction

endpackage

// File: rtl/ring_inj_fifo.sv
// Synchronous circular source queue holding {direction, packet} entries;
// a push into a full queue is accepted when a pop happens on the same edge.
module ring_inj_fifo #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ring_inject_ctrl.sv
// Ring node traffic source: generates a fixed packet budget at slot times,
// queues it and offers it to the router. Statistics need RING_INJ_STATS_EN.
module ring_inject_ctrl
  import ring_pkg::*;
#(
  parameter int NUM_NODES            = 4,
  parameter int ROUTER_ID            = 0,
  parameter int PACKET_SIZE          = 49,
  parameter int INJECT_CYCLE         = 2,
  parameter int NUM_PACKETS_PER_NODE = 20,
  parameter int TRAFFIC_PATTERN      = 0,
  parameter int QUEUE_DEPTH          = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            clk_counter,
  input  logic [15:0]            inject_clk_ref,
  input  logic                   inj_ready,
  output logic                   inj_valid,
  output logic [PACKET_SIZE-1:0] inj_pkt,
  output logic                   inj_dir,
  output logic                   done,
  output logic [63:0]            total_packet_sent,
  output logic [31:0]            stall_count
);

  localparam int   DST_ID   = calc_dst(NUM_NODES, ROUTER_ID, TRAFFIC_PATTERN);
  localparam logic PKT_DIR  = calc_dir(NUM_NODES, ROUTER_ID, DST_ID);
  localparam int   GEN_W    = $clog2(NUM_PACKETS_PER_NODE + 1);
  localparam int   ENTRY_W  = PACKET_SIZE + 1;

  if ((NUM_NODES < 2) || ((NUM_NODES & (NUM_NODES - 1)) != 0)) begin : g_bad_nodes
    $error("NUM_NODES must be a power of two of at least 2");
  end
  if ((QUEUE_DEPTH < 2) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("QUEUE_DEPTH must be a power of two of at least 2");
  end
  if ((INJECT_CYCLE < 1) || (NUM_PACKETS_PER_NODE < 1)) begin : g_bad_timing
    $error("INJECT_CYCLE and NUM_PACKETS_PER_NODE must be positive");
  end

  inj_state_e             state_q, state_d;
  logic [GEN_W-1:0]       gen_cnt_q, gen_cnt_d;
  logic                   slot;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [PACKET_SIZE-1:0] new_pkt;
  logic [ENTRY_W-1:0]     head;

  assign slot = (inject_clk_ref == 16'd0);
  assign pop  = inj_valid && inj_ready;

  always_comb begin
    new_pkt                     = '0;
    new_pkt[VALID_BIT]          = 1'b1;
    new_pkt[TS_LSB +: TS_W]     = clk_counter;
    new_pkt[SRC_LSB +: SRC_W]   = SRC_W'(ROUTER_ID);
    new_pkt[DST_LSB +: DST_W]   = DST_W'(DST_ID);
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    gen_cnt_d = gen_cnt_q;
    push      = 1'b0;
    case (state_q)
      ST_GEN: begin
        if (slot && (!fifo_full || pop)) begin
          push      = 1'b1;
          gen_cnt_d = gen_cnt_q + GEN_W'(1);
        end
        if (gen_cnt_d >= GEN_W'(NUM_PACKETS_PER_NODE)) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_GEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_GEN;
      gen_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gen_cnt_q <= gen_cnt_d;
    end
  end

  ring_inj_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({PKT_DIR, new_pkt}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head is masked while empty so stale storage never shows on the port.
  assign inj_valid = !fifo_empty;
  assign inj_pkt   = inj_valid ? head[PACKET_SIZE-1:0] : '0;
  assign inj_dir   = inj_valid && head[PACKET_SIZE];
  assign done      = (state_q == ST_DONE);

`ifdef RING_INJ_STATS_EN
  logic [63:0] sent_q;
  logic [31:0] stall_q;
  logic        stall;

  assign stall = (state_q == ST_GEN) && slot && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      sent_q  <= '0;
      stall_q <= '0;
    end else begin
      if (pop && (sent_q != '1))    sent_q  <= sent_q + 64'd1;
      if (stall && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign total_packet_sent = sent_q;
  assign stall_count       = stall_q;
`else
  assign total_packet_sent = '0;
  assign stall_count       = '0;
`endif

endmodule
